// File: rtl/wb_gcd_bridge.sv
// Wishbone slave exposing OPA/OPB/CTRL/RESULT and driving a val/rdy GCD unit.
// Ports: wb_clk_i/wb_rst_ni, wbs_* bus, req_* and resp_* GCD streams, irq_o.
module wb_gcd_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          W         = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic           wbs_stb_i,
  input  logic           wbs_cyc_i,
  input  logic           wbs_we_i,
  input  logic [3:0]     wbs_sel_i,
  input  logic [31:0]    wbs_adr_i,
  input  logic [31:0]    wbs_dat_i,
  output logic           wbs_ack_o,
  output logic [31:0]    wbs_dat_o,
  output logic           req_val,
  output logic [2*W-1:0] req_msg,
  input  logic           req_rdy,
  input  logic           resp_val,
  input  logic [W-1:0]   resp_msg,
  output logic           resp_rdy,
  output logic           irq_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t         state_q;
  logic           ack_q;
  logic [31:0]    dat_q;
  logic [W-1:0]   opa_q, opb_q, res_q;
  logic [2*W-1:0] msg_q;
  logic           done_q, err_q, ien_q;

  logic           acc, hit, wr, rd, busy;
  logic [1:0]     off;
  logic [31:0]    bmask, rdata;
  logic [31:0]    opa_m, opb_m;
  logic [W-1:0]   opa_d, opb_d;
  logic           ctrl_wr, start, resp_fire;
  logic           done_clr;
  logic           unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // acc is the single cycle that raises ack; hit or miss both get it
  assign acc  = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign hit  = acc & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr   = hit & wbs_we_i;
  assign rd   = hit & ~wbs_we_i;
  assign off  = wbs_adr_i[3:2];
  assign busy = (state_q != S_IDLE);

  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  assign opa_m = (32'(opa_q) & ~bmask) | (wbs_dat_i & bmask);
  assign opb_m = (32'(opb_q) & ~bmask) | (wbs_dat_i & bmask);
  assign opa_d = opa_m[W-1:0];
  assign opb_d = opb_m[W-1:0];

  assign ctrl_wr   = wr & (off == 2'd2) & wbs_sel_i[0];
  assign start     = ctrl_wr & wbs_dat_i[0];
  assign resp_fire = (state_q == S_WAIT) & resp_val;
  assign done_clr  = (ctrl_wr & wbs_dat_i[2])
                   | (rd & (off == 2'd3));

  always_comb begin
    rdata = '0;
    case (off)
      2'd0: rdata = 32'(opa_q);
      2'd1: rdata = 32'(opb_q);
      2'd2: rdata = {28'd0, err_q, ien_q, done_q, busy};
      2'd3: rdata = 32'(res_q);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      msg_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ien_q   <= 1'b0;
    end else begin
      ack_q <= acc;
      // read data is sampled with the pre-edge RESULT
      dat_q <= rd ? rdata : '0;

      if (wr && off == 2'd0) opa_q <= opa_d;
      if (wr && off == 2'd1) opb_q <= opb_d;
      if (ctrl_wr) ien_q <= wbs_dat_i[1];

      // a response landing with a clear request keeps DONE set
      if (resp_fire)     done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;

      if (start && busy)                  err_q <= 1'b1;
      else if (ctrl_wr && wbs_dat_i[3])   err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            msg_q   <= {opa_q, opb_q};
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (req_rdy) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (resp_val) begin
            res_q   <= resp_msg;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign req_val   = (state_q == S_REQ);
  assign req_msg   = msg_q;
  assign resp_rdy  = (state_q == S_WAIT);
  assign irq_o     = done_q & ien_q;

endmodule

// File: doc/wb_gcd_bridge.md
WB_GCD_BRIDGE -- requirements
Module: wb_gcd_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address, 16-byte window.
REQ-002 SHALL have parameter W, default 16, GCD operand/result width (2..32).
REQ-003 SHALL have ports wb_clk_i input 1, sole clock, and wb_rst_ni input 1, asynchronous active-low reset.
REQ-004 SHALL have Wishbone slave inputs: wbs_stb_i 1, wbs_cyc_i 1, wbs_we_i 1, wbs_sel_i 4, wbs_adr_i 32, wbs_dat_i 32.
REQ-005 SHALL have Wishbone slave outputs: wbs_ack_o 1, wbs_dat_o 32.
REQ-006 SHALL have GCD request outputs req_val 1 and req_msg 2W ({A,B}), and input req_rdy 1.
REQ-007 SHALL have GCD response inputs resp_val 1 and resp_msg W, and output resp_rdy 1.
REQ-008 SHALL have output irq_o 1, level interrupt toward user_irq[0].

Function
REQ-009 SHALL decode a hit when wbs_cyc_i & wbs_stb_i & wbs_adr_i[31:4]==BASE_ADDR[31:4]; offset = wbs_adr_i[3:2].
REQ-010 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after any cyc&stb with ack low, hit or miss; a miss never hangs.
REQ-011 SHALL perform register writes on the clock edge that raises wbs_ack_o, honouring wbs_sel_i byte enables.
REQ-012 SHALL drive wbs_dat_o with read data while ack is high and 0 otherwise; a miss reads 0 and ignores writes.
REQ-013 SHALL implement offset 0 OPA (RW, bits W-1:0, upper bits read 0) and offset 1 OPB (RW, same).
REQ-014 SHALL implement offset 2 CTRL write (sel[0] only): bit0 START (pulse), bit1 IRQ_EN (stored), bit2 write-1-clears DONE, bit3 write-1-clears ERR.
REQ-015 SHALL return on offset 2 read: bit0 BUSY, bit1 DONE, bit2 IRQ_EN, bit3 ERR, others 0.
REQ-016 SHALL implement offset 3 RESULT (RO, bits W-1:0); a read clears DONE; writes ignored.
REQ-017 SHALL implement FSM IDLE, REQ, WAIT; BUSY = state!=IDLE.
REQ-018 IDLE + START: capture {OPA,OPB} into req_msg register, go REQ.
REQ-019 REQ: req_val=1 with req_msg stable; on req_rdy=1 at a clock edge go WAIT.
REQ-020 WAIT: resp_rdy=1; on resp_val=1 capture resp_msg into RESULT, set DONE, go IDLE.
REQ-021 req_val SHALL be 1 only in REQ; resp_rdy SHALL be 1 only in WAIT.
REQ-022 START while BUSY SHALL be ignored and SHALL set ERR (sticky).
REQ-023 OPA/OPB writes while BUSY SHALL update the registers but not the in-flight req_msg.
REQ-024 DONE set (response capture) and DONE clear (RESULT read or W1C) in the same cycle: set wins, RESULT takes the new value.
REQ-025 A RESULT read in the response-capture cycle SHALL return the previous RESULT.
REQ-026 irq_o SHALL equal DONE & IRQ_EN, registered-free combinational from flops.
REQ-027 START with A or B zero SHALL still be issued; the bridge does not inspect operands.

Reset
REQ-028 While wb_rst_ni=0, all flops SHALL asynchronously clear: state IDLE, OPA/OPB/RESULT/req_msg 0, DONE/ERR/IRQ_EN 0.
REQ-029 During reset outputs SHALL be wbs_ack_o=0, wbs_dat_o=0, req_val=0, resp_rdy=0, irq_o=0.
REQ-030 Reset asserted mid-transaction (REQ or WAIT) SHALL abort it; a late resp_val after reset release while IDLE SHALL be ignored.
REQ-031 Reset release SHALL be synchronous to wb_clk_i at the instantiating level; the block needs no internal synchronizer.

Verification
REQ-032 Write OPA=27, OPB=15, CTRL=0x3; model returns 3 after 5 cycles -> req_msg=0x001B_000F, RESULT=3, DONE=1, irq_o=1.
REQ-033 Hold req_rdy=0 for 10 cycles after START -> req_val stays 1, req_msg stable, BUSY=1; then req_rdy=1 -> WAIT next cycle.
REQ-034 START while BUSY -> ERR=1, no second request; CTRL write 0x8 -> ERR=0.
REQ-035 Read RESULT in the cycle resp_val arrives with DONE already 1 -> read returns old value, DONE stays 1, RESULT updated.
REQ-036 Access BASE_ADDR+0x10 -> ack after 1 cycle, read data 0, no register change; byte write sel=4'b0001 data 0xFFFF to OPA -> OPA=0x00FF.
REQ-037 Drop wb_rst_ni in WAIT -> outputs zero immediately; pulse resp_val after release -> DONE stays 0.
